// File: rtl/mcpt_pkg.sv
// Shared types, default sizes and the arm-level helper for the multi-channel pulse trigger.
package mcpt_pkg;

  localparam int DEF_DW  = 14;
  localparam int DEF_NCH = 2;

  typedef enum logic [1:0] {DISARMED, ARMED, HOLDOFF} ch_state_e;

  // Level the signal must return past before a channel may fire again.
  // Callers pass sign-extended operands and truncate the result to DW+1 bits.
  function automatic logic signed [31:0] arm_level(input logic signed [31:0] thr,
                                                   input logic [31:0]        hyst,
                                                   input logic               pos);
    return pos ? (thr - $signed(hyst)) : (thr + $signed(hyst));
  endfunction

endpackage

// File: rtl/pulse_trig_channel.sv
// One trigger channel: registered sample, DW+1-bit comparators, arm/fire/holdoff FSM.
module pulse_trig_channel
  import mcpt_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [DW-1:0]        sample_i,
  input  logic [DW-1:0]        thr_i,
  input  logic [DW-1:0]        hyst_i,
  input  logic                 pol_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic                 trig_o
);

  ch_state_e             state_q;
  logic [DW-1:0]         sample_q;
  logic                  valid_q;
  logic [HOLDOFF_W-1:0]  hold_q;
  logic                  trig_q;

  logic signed [DW:0]    x_ext;
  logic signed [DW:0]    thr_ext;
  logic signed [DW:0]    arm_lvl;
  logic                  arm_side;
  logic                  fire_side;

  always_comb begin
    x_ext     = (DW+1)'($signed(sample_q));
    thr_ext   = (DW+1)'($signed(thr_i));
    arm_lvl   = (DW+1)'(arm_level(32'(thr_ext), 32'(hyst_i), pol_i));
    arm_side  = pol_i ? (x_ext <= arm_lvl) : (x_ext >= arm_lvl);
    fire_side = pol_i ? (x_ext > thr_ext) : (x_ext < thr_ext);
  end

  // valid_q keeps the reset value of sample_q from arming the channel after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= DISARMED;
      sample_q <= '0;
      valid_q  <= 1'b0;
      hold_q   <= '0;
      trig_q   <= 1'b0;
    end else begin
      sample_q <= sample_i;
      valid_q  <= 1'b1;
      trig_q   <= 1'b0;
      if (!en_i) begin
        state_q <= DISARMED;
        hold_q  <= '0;
      end else if (valid_q) begin
        case (state_q)
          DISARMED: if (arm_side) state_q <= ARMED;
          ARMED: begin
            if (fire_side) begin
              state_q <= HOLDOFF;
              hold_q  <= holdoff_i;
              trig_q  <= 1'b1;
            end
          end
          HOLDOFF: begin
            if (hold_q == '0) state_q <= DISARMED;
            else              hold_q  <= hold_q - HOLDOFF_W'(1);
          end
          default: state_q <= DISARMED;
        endcase
      end
    end
  end

  assign trig_o = trig_q;

endmodule

// File: rtl/multi_channel_pulse_trigger.sv
// N-channel threshold trigger with OR/coincidence combiner, aligned data delay and event counter.
module multi_channel_pulse_trigger
  import mcpt_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int NCH       = DEF_NCH,
  parameter int HOLDOFF_W = 16,
  parameter int COINC_W   = 8,
  parameter int CNT_W     = 32
) (
  input  logic                 adc_clk,
  input  logic                 adc_rstn,
  input  logic [NCH*DW-1:0]    adc_dat_i,
  input  logic [NCH*DW-1:0]    threshold,
  input  logic [NCH*DW-1:0]    hysteresis,
  input  logic [NCH-1:0]       polarity,
  input  logic [NCH-1:0]       ch_en,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 coinc_mode,
  input  logic [COINC_W-1:0]   coinc_win,
  input  logic                 cnt_clr,
  output logic [NCH-1:0]       trig_ch,
  output logic                 trig_any,
  output logic [NCH*DW-1:0]    adc_dat_o,
  output logic [CNT_W-1:0]     event_cnt
);

  localparam int DLY = 3;

  logic [NCH*DW-1:0]  dly_q [DLY];
  logic [COINC_W-1:0] stretch_q [NCH];
  logic               trig_any_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [NCH-1:0]     fire;
  logic [NCH-1:0]     recent;
  logic               coinc_hit;
  logic               any_d;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    pulse_trig_channel #(
      .DW        (DW),
      .HOLDOFF_W (HOLDOFF_W)
    ) u_ch (
      .clk_i     (adc_clk),
      .rst_ni    (adc_rstn),
      .en_i      (ch_en[gi]),
      .sample_i  (adc_dat_i[gi*DW +: DW]),
      .thr_i     (threshold[gi*DW +: DW]),
      .hyst_i    (hysteresis[gi*DW +: DW]),
      .pol_i     (polarity[gi]),
      .holdoff_i (holdoff),
      .trig_o    (trig_ch[gi])
    );
  end

  always_comb begin
    fire = trig_ch & ch_en;
    for (int k = 0; k < NCH; k++) recent[k] = fire[k] || (stretch_q[k] != '0);
    coinc_hit = (|ch_en) && (&(recent | ~ch_en)) && (|fire);
    any_d     = coinc_mode ? coinc_hit : (|fire);
  end

  // Stretch counters only run in coincidence mode, so a mode change always starts them from 0.
  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      for (int k = 0; k < NCH; k++) stretch_q[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (!coinc_mode || coinc_hit || !ch_en[k]) stretch_q[k] <= '0;
        else if (fire[k])                          stretch_q[k] <= coinc_win;
        else if (stretch_q[k] != '0)               stretch_q[k] <= stretch_q[k] - COINC_W'(1);
      end
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      trig_any_q <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < DLY; i++) dly_q[i] <= '0;
    end else begin
      trig_any_q <= any_d;
      if (cnt_clr)                         cnt_q <= '0;
      else if (trig_any_q && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      dly_q[0] <= adc_dat_i;
      for (int i = 1; i < DLY; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign trig_any  = trig_any_q;
  assign event_cnt = cnt_q;
  assign adc_dat_o = dly_q[DLY-1];

endmodule

// File: tb/tb_multi_channel_pulse_trigger.sv
// Directed bench: an event-time model of the trigger checked every cycle, plus literal pins.
module tb_multi_channel_pulse_trigger;
  localparam int DW = 14, NCH = 2, HOLDOFF_W = 16, COINC_W = 8, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                 adc_clk = 1'b0;
  logic                 adc_rstn = 1'b0;
  logic [NCH*DW-1:0]    adc_dat_i, threshold, hysteresis;
  logic [NCH-1:0]       polarity = '0, ch_en = '0;
  logic [HOLDOFF_W-1:0] holdoff = '0;
  logic                 coinc_mode = 1'b0;
  logic [COINC_W-1:0]   coinc_win = '0;
  logic                 cnt_clr = 1'b0;
  logic [NCH-1:0]       trig_ch;
  logic                 trig_any;
  logic [NCH*DW-1:0]    adc_dat_o;
  logic [CNT_W-1:0]     event_cnt;

  int samp[NCH], thr_v[NCH], hyst_v[NCH];
  int n_cmp = 0, n_bad = 0;
  int fire_seen[NCH], any_seen = 0, base;

  multi_channel_pulse_trigger #(
    .DW(DW), .NCH(NCH), .HOLDOFF_W(HOLDOFF_W), .COINC_W(COINC_W), .CNT_W(CNT_W)
  ) dut (
    .adc_clk(adc_clk), .adc_rstn(adc_rstn), .adc_dat_i(adc_dat_i), .threshold(threshold),
    .hysteresis(hysteresis), .polarity(polarity), .ch_en(ch_en), .holdoff(holdoff),
    .coinc_mode(coinc_mode), .coinc_win(coinc_win), .cnt_clr(cnt_clr), .trig_ch(trig_ch),
    .trig_any(trig_any), .adc_dat_o(adc_dat_o), .event_cnt(event_cnt)
  );

  always #5 adc_clk = ~adc_clk;

  always_comb begin
    adc_dat_i = '0; threshold = '0; hysteresis = '0;
    for (int k = 0; k < NCH; k++) begin
      adc_dat_i[k*DW +: DW]  = DW'(samp[k]);
      threshold[k*DW +: DW]  = DW'(thr_v[k]);
      hysteresis[k*DW +: DW] = DW'(hyst_v[k]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model state: per channel an armed flag, the last edge still spent in holdoff,
  // and the last edge on which a past fire still counts as recent for coincidence.
  longint            edge_i;
  int                m_prev[NCH];
  bit                m_prev_v;
  bit                m_armed[NCH];
  longint            m_release[NCH], m_expiry[NCH];
  logic [NCH-1:0]    e_trig;
  logic              e_any;
  int                e_cnt;
  logic [NCH*DW-1:0] e_dat;
  logic [NCH*DW-1:0] hist[$];

  initial forever begin
    @(posedge adc_clk or negedge adc_rstn);
    if (!adc_rstn) begin
      edge_i = 0; m_prev_v = 0; e_trig = '0; e_any = 0; e_cnt = 0; e_dat = '0;
      for (int k = 0; k < NCH; k++) begin
        m_prev[k] = 0; m_armed[k] = 0; m_release[k] = -1; m_expiry[k] = -1;
      end
      hist.delete(); hist.push_back('0); hist.push_back('0);
    end else begin : model_step
      logic [NCH-1:0] fire, nt;
      bit all_recent, hit;
      edge_i++;
      fire = e_trig & ch_en;
      if (coinc_mode) begin
        all_recent = 1;
        for (int k = 0; k < NCH; k++)
          if (ch_en[k] && !(fire[k] || edge_i <= m_expiry[k])) all_recent = 0;
        hit = (ch_en != '0) && all_recent && (fire != '0);
      end else hit = (fire != '0);
      for (int k = 0; k < NCH; k++) begin
        if (!coinc_mode || hit || !ch_en[k]) m_expiry[k] = -1;
        else if (fire[k])                    m_expiry[k] = edge_i + longint'(coinc_win);
      end
      if (cnt_clr) e_cnt = 0;
      else if (e_any && e_cnt < CNT_MAX) e_cnt++;
      e_any = hit;
      nt = '0;
      for (int k = 0; k < NCH; k++) begin
        int x, t, h;
        x = m_prev[k]; t = thr_v[k]; h = hyst_v[k];
        if (!ch_en[k]) begin
          m_armed[k] = 0; m_release[k] = -1;
        end else if (m_prev_v && edge_i > m_release[k]) begin
          if (!m_armed[k]) begin
            if (polarity[k] ? (x <= t - h) : (x >= t + h)) m_armed[k] = 1;
          end else if (polarity[k] ? (x > t) : (x < t)) begin
            nt[k] = 1'b1; m_armed[k] = 0;
            m_release[k] = edge_i + longint'(holdoff) + 1;
          end
        end
      end
      for (int k = 0; k < NCH; k++) m_prev[k] = samp[k];
      m_prev_v = 1;
      e_trig = nt;
      hist.push_back(adc_dat_i);
      e_dat = hist.pop_front();
    end
  end

  initial forever begin
    @(negedge adc_clk);
    chk("trig_ch", 64'(trig_ch), 64'(e_trig));
    chk("trig_any", 64'(trig_any), 64'(e_any));
    chk("adc_dat_o", 64'(adc_dat_o), 64'(e_dat));
    chk("event_cnt", 64'(event_cnt), 64'(e_cnt));
    for (int k = 0; k < NCH; k++) fire_seen[k] += int'(trig_ch[k]);
    any_seen += int'(trig_any);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) begin
      samp[k] = 0; thr_v[k] = 0; hyst_v[k] = 0; fire_seen[k] = 0;
    end
    tick(2);
    chk("rst_trig_ch", 64'(trig_ch), 0);
    chk("rst_trig_any", 64'(trig_any), 0);
    chk("rst_event_cnt", 64'(event_cnt), 0);
    chk("rst_adc_dat_o", 64'(adc_dat_o), 0);
    adc_rstn = 1'b1;

    // Positive ramp on ch0, OR mode.
    for (int k = 0; k < NCH; k++) begin
      thr_v[k] = 1000; hyst_v[k] = 50; samp[k] = 900;
    end
    polarity = 2'b11; holdoff = 16'd10; coinc_win = 8'd5; ch_en = 2'b01;
    tick(3);
    samp[0] = 950;  tick(1);
    samp[0] = 1000; tick(1);
    samp[0] = 1001; tick(1);
    samp[0] = 1050; tick(1);
    chk("ramp_fire", 64'(trig_ch), 64'(2'b01));
    samp[0] = 1100; tick(1);
    chk("ramp_one_cycle", 64'(trig_ch), 0);
    chk("ramp_any", 64'(trig_any), 1);
    chk("ramp_align", 64'(adc_dat_o[DW-1:0]), 64'(14'd1001));
    samp[0] = 900;  tick(1);
    samp[0] = 1100; tick(4);
    chk("holdoff_block", fire_seen[0], 1);

    // Dither inside the hysteresis band, then a proper re-arm.
    samp[0] = 1010; tick(12);
    for (int i = 0; i < 10; i++) begin
      samp[0] = 990;  tick(1);
      samp[0] = 1010; tick(1);
    end
    chk("dither_no_fire", fire_seen[0], 1);
    samp[0] = 940;  tick(1);
    samp[0] = 1001; tick(4);
    chk("rearm_fire", fire_seen[0], 2);

    // Negative polarity, then the most negative threshold in both polarities.
    ch_en = 2'b00; tick(1);
    polarity[0] = 1'b0; thr_v[0] = -2000; hyst_v[0] = 100; samp[0] = -1800; ch_en = 2'b01;
    tick(3);
    samp[0] = -2001; tick(4);
    chk("neg_fire", fire_seen[0], 3);
    ch_en = 2'b00; polarity[0] = 1'b1; thr_v[0] = -8192; samp[0] = -8192; tick(2);
    ch_en = 2'b01; tick(3);
    samp[0] = 8000;  tick(3);
    samp[0] = -8192; tick(3);
    samp[0] = 8191;  tick(3);
    chk("minthr_pos", fire_seen[0], 3);
    ch_en = 2'b00; tick(1);
    polarity[0] = 1'b0; samp[0] = 0; ch_en = 2'b01; tick(3);
    samp[0] = -8192; tick(3);
    chk("minthr_neg", fire_seen[0], 3);

    // Coincidence: ch1 four cycles after ch0 is inside a window of 5, six is not.
    ch_en = 2'b00; tick(1);
    coinc_mode = 1'b1; holdoff = 16'd20; polarity = 2'b11; thr_v[0] = 1000; hyst_v[0] = 50;
    samp[0] = 900; samp[1] = 900; ch_en = 2'b11; tick(3);
    samp[0] = 1100; tick(4);
    samp[1] = 1100; tick(3);
    chk("coinc_in_win", 64'(trig_any), 1);
    tick(4);
    chk("coinc_one", any_seen, 4);
    samp[0] = 900; samp[1] = 900; tick(30);
    samp[0] = 1100; tick(6);
    samp[1] = 1100; tick(6);
    chk("coinc_outside", any_seen, 4);
    chk("coinc_ch1_fires", fire_seen[1], 2);

    // OR mode with simultaneous fires, then counter saturation and clear priority.
    coinc_mode = 1'b0; samp[0] = 900; samp[1] = 900; tick(30);
    samp[0] = 1100; samp[1] = 1100; tick(4);
    chk("or_same_cycle", any_seen, 5);
    tick(25);
    ch_en = 2'b01; holdoff = 16'd0;
    for (int i = 0; i < 14; i++) begin
      samp[0] = 900;  tick(3);
      samp[0] = 1100; tick(3);
    end
    tick(2);
    chk("evt_sat", 64'(event_cnt), 15);
    samp[0] = 900;  tick(3);
    samp[0] = 1100; tick(3);
    chk("clr_any", 64'(trig_any), 1);
    cnt_clr = 1'b1; tick(1);
    cnt_clr = 1'b0;
    chk("clr_prio", 64'(event_cnt), 0);

    // Reset during a trigger pulse in HOLDOFF; the channel must re-arm afterwards.
    holdoff = 16'd10;
    samp[0] = 900;  tick(3);
    samp[0] = 1100; tick(2);
    chk("pre_rst_trig", 64'(trig_ch), 64'(2'b01));
    adc_rstn = 1'b0;
    #1;
    chk("rst_mid_trig_ch", 64'(trig_ch), 0);
    chk("rst_mid_trig_any", 64'(trig_any), 0);
    chk("rst_mid_event_cnt", 64'(event_cnt), 0);
    chk("rst_mid_adc_dat_o", 64'(adc_dat_o), 0);
    tick(2);
    base = fire_seen[0];
    adc_rstn = 1'b1;
    tick(6);
    chk("rst_no_fire", fire_seen[0] - base, 0);
    samp[0] = 900;  tick(3);
    samp[0] = 1100; tick(4);
    chk("rst_rearm", fire_seen[0] - base, 1);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_channel_pulse_trigger.md
Name: multi_channel_pulse_trigger

Overview:
Parametrised N-channel threshold trigger for the muon-decay ADC front end. Each channel has a per-channel threshold, hysteresis, polarity and enable, and is re-armed only after the signal returns past the hysteresis band. A shared holdoff, an OR/coincidence combiner and a saturating event counter are included. ADC data is passed through, delay-matched to the combined trigger so the downstream capture logic sees the triggering sample.

Parameters:
DW, 14, ADC sample width; two's-complement signed.
NCH, 2, number of channels.
HOLDOFF_W, 16, width of the holdoff counter.
COINC_W, 8, width of the coincidence window counter.
CNT_W, 32, width of the event counter.

Ports:
adc_clk  in  1  sample clock; all logic on its rising edge.
adc_rstn  in  1  asynchronous active-low reset.
adc_dat_i  in  NCH*DW  packed samples; channel k at bits [k*DW +: DW].
threshold  in  NCH*DW  signed per-channel threshold.
hysteresis  in  NCH*DW  unsigned per-channel re-arm margin.
polarity  in  NCH  1 = fire on rising crossing (x > thr); 0 = fire on falling crossing (x < thr).
ch_en  in  NCH  per-channel enable.
holdoff  in  HOLDOFF_W  cycles spent in HOLDOFF after a fire.
coinc_mode  in  1  0 = OR of enabled channels; 1 = coincidence of all enabled channels.
coinc_win  in  COINC_W  coincidence window in cycles.
cnt_clr  in  1  synchronous clear of the event counter.
trig_ch  out  NCH  per-channel one-cycle fire pulse.
trig_any  out  1  combined one-cycle trigger pulse.
adc_dat_o  out  NCH*DW  adc_dat_i delayed by 3 cycles.
event_cnt  out  CNT_W  number of trig_any pulses, saturating.

Behaviour:
- Reset: trig_ch = 0, trig_any = 0, adc_dat_o = 0, event_cnt = 0. All channel FSMs go to DISARMED. All holdoff and stretch counters go to 0.
- Stage 1: register the samples. Compare in DW+1 bits, sign-extended; arm level = thr − hyst (pos polarity) or thr + hyst (neg polarity). The extra bit means no wrap at the extremes.
- Channel FSM, evaluated on the stage-1 sample:
  - DISARMED → ARMED when the sample is on the arm side of the arm level (pos: x ≤ thr−hyst; neg: x ≥ thr+hyst).
  - ARMED → HOLDOFF when the sample crosses the threshold strictly (pos: x > thr; neg: x < thr). trig_ch[k] is asserted for exactly that one cycle.
  - HOLDOFF: load holdoff on entry and count down; go to DISARMED when the count is 0. holdoff = 0 means exactly one cycle in HOLDOFF.
  - ch_en[k] = 0 forces DISARMED, clears the counters and holds trig_ch[k] = 0 from the next cycle.
  - A sample already past the threshold when the channel is enabled never fires until the signal re-arms.
- Latency: sample presented at cycle N → trig_ch at N+2 → trig_any at N+3. adc_dat_o is delayed 3 cycles so it aligns with trig_any.
- Combiner, OR mode: trig_any = OR of trig_ch over enabled channels, registered.
- Combiner, coincidence mode:
  - Each fire loads a per-channel stretch counter with coinc_win.
  - A channel is "recent" while its counter > 0 or while it fires this cycle.
  - trig_any fires when all enabled channels are recent and at least one fires this cycle; on that fire, all stretch counters clear.
  - coinc_win = 0 requires same-cycle fires.
  - No channels enabled means trig_any never fires.
  - Changing coinc_mode clears the stretch counters.
- event_cnt increments on trig_any and saturates at all-ones. cnt_clr has priority over an increment in the same cycle.
- Parameter inputs (threshold, hysteresis, holdoff, etc.) are sampled live each cycle. Software changes them only while the channel is disabled.

Decomposition:
- Package mcpt_pkg holds:
  - channel state enum {DISARMED, ARMED, HOLDOFF};
  - default DW/NCH constants;
  - a helper function for the signed (DW+1)-bit arm-level computation.
- Sub-module pulse_trig_channel: one channel's comparator, FSM and holdoff counter, instantiated NCH times with generate. The combiner, delay line and counter stay in the top level.

Test Plan:
- NCH=2, ch0 pos, thr=1000, hyst=50, holdoff=10; ramp 900→1100 → trig_ch[0] one cycle, 2 cycles after the first sample of 1001. A second crossing inside holdoff gives no fire.
- ch0 dithers 990↔1010 after a fire, never ≤ 950 → no further fire. A drop to 940 then 1001 → one fire.
- Neg polarity, thr=−2000, hyst=100; samples go −1800 then −2001 → one fire. Also run thr=−8192, hyst=100 (DW=14) → no wrap and no spurious arm.
- coinc_mode=1, win=5; ch0 fires at t, ch1 at t+4 → one trig_any at ch1 fire + 1 cycle. Repeat with ch1 at t+6 → no trig_any.
- OR mode, both channels fire the same cycle → one trig_any. event_cnt at all-ones stays saturated. cnt_clr together with trig_any → 0.
- adc_rstn asserted mid-HOLDOFF and during a trig pulse → outputs 0 immediately, FSM DISARMED. After release, the channel must re-arm before it fires.
